exe_alu_stage: RTL and testbench

Execute-stage ALU with the NZCV status register and the EX/MEM output register. It sits directly downstream of the second-operand generator. It takes `val_1` from the register file path and `val_2` from the operand generator, computes the ARM data-processing result, and updates flags when the S bit is set. It registers the result and the pass-through control fields for the memory stage. The status register output feeds the decode-stage condition check.

---
 rtl/exe_alu_stage.sv | 129 ++++++++++++
 tb/tb_exe_alu_stage.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/exe_alu_stage.sv
// Execute-stage ALU: ARM data-processing result, NZCV status register and
// the EX/MEM pipeline register feeding the memory stage.
module exe_alu_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        freeze,
    input  logic        flush,
    input  logic        in_valid,
    input  logic [3:0]  exe_cmd,
    input  logic        s_bit,
    input  logic [31:0] val_1,
    input  logic [31:0] val_2,
    input  logic        wb_en_in,
    input  logic        mem_r_en_in,
    input  logic        mem_w_en_in,
    input  logic [3:0]  dest_in,
    input  logic [31:0] st_val_in,
    output logic [31:0] alu_result,
    output logic [3:0]  status,
    output logic        out_valid,
    output logic        wb_en,
    output logic        mem_r_en,
    output logic        mem_w_en,
    output logic [3:0]  dest,
    output logic [31:0] st_val
);

    localparam logic [3:0] CMD_MOV = 4'b0001;
    localparam logic [3:0] CMD_MVN = 4'b1001;
    localparam logic [3:0] CMD_ADD = 4'b0010;
    localparam logic [3:0] CMD_ADC = 4'b0011;
    localparam logic [3:0] CMD_SUB = 4'b0100;
    localparam logic [3:0] CMD_SBC = 4'b0101;
    localparam logic [3:0] CMD_AND = 4'b0110;
    localparam logic [3:0] CMD_ORR = 4'b0111;
    localparam logic [3:0] CMD_EOR = 4'b1000;

    logic        c_flag;
    logic        v_flag;
    logic        arith;
    logic [31:0] add_b;
    logic        add_cin;
    logic [32:0] sum;
    logic [31:0] result;
    logic [3:0]  next_status;
    logic        status_we;

    assign c_flag = status[1];
    assign v_flag = status[0];

    // Adder operand/carry selection; subtraction is a + ~b + cin so the
    // carry-out is NOT-borrow.
    always_comb begin
        arith   = 1'b0;
        add_b   = val_2;
        add_cin = 1'b0;
        unique case (exe_cmd)
            CMD_ADD: begin arith = 1'b1; add_b = val_2;  add_cin = 1'b0;   end
            CMD_ADC: begin arith = 1'b1; add_b = val_2;  add_cin = c_flag; end
            CMD_SUB: begin arith = 1'b1; add_b = ~val_2; add_cin = 1'b1;   end
            CMD_SBC: begin arith = 1'b1; add_b = ~val_2; add_cin = c_flag; end
            default: begin arith = 1'b0; add_b = val_2;  add_cin = 1'b0;   end
        endcase
    end

    assign sum = {1'b0, val_1} + {1'b0, add_b} + {32'd0, add_cin};

    always_comb begin
        result = '0;
        unique case (exe_cmd)
            CMD_MOV: result = val_2;
            CMD_MVN: result = ~val_2;
            CMD_ADD,
            CMD_ADC,
            CMD_SUB,
            CMD_SBC: result = sum[31:0];
            CMD_AND: result = val_1 & val_2;
            CMD_ORR: result = val_1 | val_2;
            CMD_EOR: result = val_1 ^ val_2;
            default: result = '0;
        endcase
    end

    // Logical, move and undefined codes leave C and V untouched.
    always_comb begin
        next_status[3] = result[31];
        next_status[2] = (result == 32'd0);
        next_status[1] = arith ? sum[32] : c_flag;
        next_status[0] = arith ? ((val_1[31] == add_b[31]) && (result[31] != val_1[31]))
                               : v_flag;
    end

    assign status_we = in_valid && s_bit && !flush && !freeze;

    always_ff @(posedge clk) begin
        if (!rst) begin
            status <= '0;
        end else if (status_we) begin
            status <= next_status;
        end
    end

    // Flush outranks freeze: it clears the valid/control bits while data holds.
    always_ff @(posedge clk) begin
        if (!rst) begin
            alu_result <= '0;
            out_valid  <= 1'b0;
            wb_en      <= 1'b0;
            mem_r_en   <= 1'b0;
            mem_w_en   <= 1'b0;
            dest       <= '0;
            st_val     <= '0;
        end else if (flush) begin
            out_valid  <= 1'b0;
            wb_en      <= 1'b0;
            mem_r_en   <= 1'b0;
            mem_w_en   <= 1'b0;
        end else if (!freeze) begin
            alu_result <= result;
            out_valid  <= in_valid;
            wb_en      <= wb_en_in & in_valid;
            mem_r_en   <= mem_r_en_in & in_valid;
            mem_w_en   <= mem_w_en_in & in_valid;
            dest       <= dest_in;
            st_val     <= st_val_in;
        end
    end

endmodule

// File: tb/tb_exe_alu_stage.sv
// Scoreboard bench for exe_alu_stage: stimulus pushes hand-computed expected
// outputs, a negedge monitor pops and compares whenever out_valid is high.
module tb_exe_alu_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        freeze;
    logic        flush;
    logic        in_valid;
    logic [3:0]  exe_cmd;
    logic        s_bit;
    logic [31:0] val_1;
    logic [31:0] val_2;
    logic        wb_en_in;
    logic        mem_r_en_in;
    logic        mem_w_en_in;
    logic [3:0]  dest_in;
    logic [31:0] st_val_in;
    logic [31:0] alu_result;
    logic [3:0]  status;
    logic        out_valid;
    logic        wb_en;
    logic        mem_r_en;
    logic        mem_w_en;
    logic [3:0]  dest;
    logic [31:0] st_val;

    exe_alu_stage dut (
        .clk         (clk),
        .rst         (rst),
        .freeze      (freeze),
        .flush       (flush),
        .in_valid    (in_valid),
        .exe_cmd     (exe_cmd),
        .s_bit       (s_bit),
        .val_1       (val_1),
        .val_2       (val_2),
        .wb_en_in    (wb_en_in),
        .mem_r_en_in (mem_r_en_in),
        .mem_w_en_in (mem_w_en_in),
        .dest_in     (dest_in),
        .st_val_in   (st_val_in),
        .alu_result  (alu_result),
        .status      (status),
        .out_valid   (out_valid),
        .wb_en       (wb_en),
        .mem_r_en    (mem_r_en),
        .mem_w_en    (mem_w_en),
        .dest        (dest),
        .st_val      (st_val)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] r;
        logic [3:0]  st;
        logic        wb;
        logic        mr;
        logic        mw;
        logic [3:0]  d;
        logic [31:0] sv;
    } exp_t;

    exp_t q[$];
    exp_t last_e;
    int   checks = 0;
    int   errors = 0;
    logic [3:0] tag = 4'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output actual=%h required=none t=%0t", alu_result, $time);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("alu_result", alu_result, e.r);
                chk("status", {28'd0, status}, {28'd0, e.st});
                chk("controls", {29'd0, wb_en, mem_r_en, mem_w_en}, {29'd0, e.wb, e.mr, e.mw});
                chk("dest", {28'd0, dest}, {28'd0, e.d});
                chk("st_val", st_val, e.sv);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one valid instruction and push its hand-computed expected output.
    task automatic op(input logic [3:0] cmd, input logic s, input logic [31:0] a,
                      input logic [31:0] b, input logic wb, input logic mr, input logic mw,
                      input logic [31:0] er, input logic [3:0] est);
        in_valid    = 1'b1;
        freeze      = 1'b0;
        flush       = 1'b0;
        exe_cmd     = cmd;
        s_bit       = s;
        val_1       = a;
        val_2       = b;
        wb_en_in    = wb;
        mem_r_en_in = mr;
        mem_w_en_in = mw;
        dest_in     = tag;
        st_val_in   = 32'h1000 + {28'd0, tag};
        last_e      = '{r: er, st: est, wb: wb, mr: mr, mw: mw, d: tag, sv: 32'h1000 + {28'd0, tag}};
        q.push_back(last_e);
        tag         = tag + 4'd1;
        tick();
    endtask

    task automatic check_all_zero(input string name);
        chk({name, "_result"}, alu_result, 32'd0);
        chk({name, "_flags"}, {22'd0, status, out_valid, wb_en, mem_r_en, mem_w_en, dest}, 32'd0);
        chk({name, "_st_val"}, st_val, 32'd0);
    endtask

    initial begin
        rst = 1'b0; freeze = 1'b0; flush = 1'b0;
        in_valid = 1'b1; exe_cmd = 4'b0010; s_bit = 1'b1;
        val_1 = '0; val_2 = '0; wb_en_in = 1'b1; mem_r_en_in = 1'b1; mem_w_en_in = 1'b1;
        dest_in = '0; st_val_in = '0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            val_1 = $urandom; val_2 = $urandom; st_val_in = $urandom;
            exe_cmd = 4'($urandom); dest_in = 4'($urandom);
            s_bit = 1'($urandom); freeze = 1'($urandom); flush = 1'($urandom);
            tick();
        end
        check_all_zero("reset");
        rst = 1'b1;

        op(4'b0010, 1'b0, 32'd2, 32'd3, 1'b1, 1'b0, 1'b0, 32'd5, 4'b0000);
        op(4'b0010, 1'b1, 32'h7FFFFFFF, 32'd1, 1'b1, 1'b0, 1'b0, 32'h80000000, 4'b1001);
        op(4'b0010, 1'b1, 32'hFFFFFFFF, 32'd1, 1'b0, 1'b1, 1'b0, 32'h00000000, 4'b0110);
        op(4'b0100, 1'b1, 32'd3, 32'd5, 1'b1, 1'b0, 1'b0, 32'hFFFFFFFE, 4'b1000);
        op(4'b0101, 1'b0, 32'd10, 32'd2, 1'b1, 1'b0, 1'b0, 32'd7, 4'b1000);
        op(4'b0100, 1'b1, 32'h80000000, 32'd1, 1'b0, 1'b0, 1'b1, 32'h7FFFFFFF, 4'b0011);
        op(4'b0110, 1'b1, 32'hF0, 32'h0F, 1'b0, 1'b0, 1'b0, 32'h0, 4'b0111);
        op(4'b1001, 1'b1, 32'h12345678, 32'h0, 1'b1, 1'b0, 1'b0, 32'hFFFFFFFF, 4'b1011);
        op(4'b0011, 1'b1, 32'hFFFFFFFF, 32'd1, 1'b1, 1'b0, 1'b0, 32'd1, 4'b0010);
        op(4'b0011, 1'b1, 32'd5, 32'd6, 1'b1, 1'b0, 1'b0, 32'd12, 4'b0000);
        op(4'b0101, 1'b1, 32'd10, 32'd2, 1'b1, 1'b0, 1'b0, 32'd7, 4'b0010);
        op(4'b0101, 1'b1, 32'd7, 32'd7, 1'b1, 1'b0, 1'b0, 32'd0, 4'b0110);
        op(4'b0001, 1'b1, 32'hDEADBEEF, 32'h80000000, 1'b1, 1'b0, 1'b0, 32'h80000000, 4'b1010);
        op(4'b1111, 1'b1, 32'd5, 32'd6, 1'b1, 1'b0, 1'b0, 32'd0, 4'b0110);
        op(4'b1000, 1'b1, 32'hFF, 32'h0F, 1'b1, 1'b0, 1'b0, 32'hF0, 4'b0010);
        op(4'b0111, 1'b0, 32'h100, 32'h1, 1'b1, 1'b0, 1'b1, 32'h101, 4'b0010);

        // Frozen ADDS: the ORR output and status 0010 must be presented unchanged.
        exe_cmd = 4'b0010; s_bit = 1'b1; val_1 = 32'd1; val_2 = 32'd2;
        in_valid = 1'b1; wb_en_in = 1'b1; mem_r_en_in = 1'b0; mem_w_en_in = 1'b0;
        dest_in = 4'hE; st_val_in = 32'hCAFE;
        freeze = 1'b1;
        for (int i = 0; i < 3; i++) begin
            q.push_back(last_e);
            tick();
        end
        freeze = 1'b0;
        last_e = '{r: 32'd3, st: 4'b0000, wb: 1'b1, mr: 1'b0, mw: 1'b0, d: 4'hE, sv: 32'hCAFE};
        q.push_back(last_e);
        tick();

        // Flush with freeze: valid/controls drop, status keeps 0000.
        exe_cmd = 4'b0010; s_bit = 1'b1; val_1 = 32'hFFFFFFFF; val_2 = 32'd1;
        wb_en_in = 1'b1; mem_w_en_in = 1'b1; freeze = 1'b1; flush = 1'b1;
        tick();
        chk("flush_valid", {31'd0, out_valid}, 32'd0);
        chk("flush_ctrl", {29'd0, wb_en, mem_r_en, mem_w_en}, 32'd0);
        chk("flush_status", {28'd0, status}, 32'd0);
        chk("flush_result_hold", alu_result, 32'd3);

        // Invalid slot: controls gated off by in_valid.
        freeze = 1'b0; flush = 1'b0; in_valid = 1'b0; s_bit = 1'b1;
        tick();
        chk("idle_valid", {28'd0, out_valid, wb_en, mem_r_en, mem_w_en}, 32'd0);
        chk("idle_status", {28'd0, status}, 32'd0);

        op(4'b0100, 1'b1, 32'd5, 32'd3, 1'b1, 1'b1, 1'b0, 32'd2, 4'b0010);

        // Mid-operation reset overrides freeze and flush.
        rst = 1'b0; in_valid = 1'b1; freeze = 1'b1; flush = 1'b0;
        exe_cmd = 4'b0010; val_1 = 32'd9; val_2 = 32'd9;
        tick();
        check_all_zero("midreset");
        rst = 1'b1; freeze = 1'b0; in_valid = 1'b0;
        tick();
        tick();
        chk("queue_drained", q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
